// File: rtl/sel_n_1_hs_if.sv
// sel_n_1_hs_if: per-channel producer handshakes plus the single consumer handshake of sel_n_1_hs.
interface sel_n_1_hs_if #(
    parameter int WIDTH = 8,
    parameter int CH    = 4,
    parameter int SEL_W = 2
);
    logic [CH*WIDTH-1:0] in_data;
    logic [CH-1:0]       in_valid;
    logic [CH-1:0]       in_ready;
    logic                mode;
    logic [SEL_W-1:0]    sel;
    logic [WIDTH-1:0]    out;
    logic                out_valid;
    logic                out_ready;
    logic [SEL_W-1:0]    out_ch;
    modport master (output in_data, in_valid, mode, sel, out_ready,
                    input  in_ready, out, out_valid, out_ch);
    modport slave  (input  in_data, in_valid, mode, sel, out_ready,
                    output in_ready, out, out_valid, out_ch);
endinterface

// File: rtl/sel_n_1_hs.sv
// sel_n_1_hs: registered N-to-1 selector with valid/ready handshakes, fixed or round-robin select.
// Optional SEL_LOCK_EN keeps round-robin grants on one channel for up to MAX_BURST transfers.
module sel_n_1_hs #(
    parameter int WIDTH     = 8,
    parameter int CH        = 4,
    parameter int SEL_W     = 2,
    parameter int MAX_BURST = 4
) (
    input  logic         clk,
    input  logic         rst,
    sel_n_1_hs_if.slave  bus
);
    if (CH < 2 || CH > 16 || (1 << SEL_W) < CH || MAX_BURST < 1) begin : g_bad_params
        $error("sel_n_1_hs: illegal parameter combination");
    end
    logic             load_en, any, granted, xfer, lock;
    logic [SEL_W-1:0] g, g_rr, ptr;
    logic [WIDTH-1:0] d;
    // Round-robin search: lowest offset from ptr wins, so scan offsets high to low.
    always_comb begin
        logic [SEL_W-1:0] c;
        c = '0;
        any = 1'b0;
        g_rr = '0;
        for (int k = CH - 1; k >= 0; k--) begin
            c = SEL_W'((int'(ptr) + k) % CH);
            if (bus.in_valid[c]) begin
                any = 1'b1;
                g_rr = c;
            end
        end
    end
`ifdef SEL_LOCK_EN
    localparam int CW = $clog2(MAX_BURST + 1);
    logic [CW-1:0] cnt;
    // out_ch always names the last granted channel; cnt==0 means no burst in progress.
    assign lock = bus.mode && cnt != '0 && int'(cnt) < MAX_BURST && bus.in_valid[bus.out_ch];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else if (!bus.mode) cnt <= '0;
        else if (xfer) cnt <= lock ? cnt + 1'b1 : CW'(1);
        else if (!bus.in_valid[bus.out_ch]) cnt <= '0;
    end
`else
    assign lock = 1'b0;
`endif
    always_comb begin
        load_en = !bus.out_valid | bus.out_ready;
        g = bus.mode ? (lock ? bus.out_ch : g_rr) : bus.sel;
        granted = bus.mode ? (lock | any) : (int'(bus.sel) < CH);
        bus.in_ready = (!rst && load_en && granted) ? CH'(1) << g : '0;
        xfer = !rst && load_en && granted && bus.in_valid[g];
        d = '0;
        for (int i = 0; i < CH; i++) d = (SEL_W'(i) == g) ? bus.in_data[i*WIDTH +: WIDTH] : d;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out <= '0;
            bus.out_valid <= 1'b0;
            bus.out_ch <= '0;
            ptr <= '0;
        end else if (load_en) begin
            bus.out_valid <= xfer;
            if (xfer) begin
                bus.out <= d;
                bus.out_ch <= g;
                ptr <= (g == SEL_W'(CH - 1)) ? '0 : g + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sel_n_1_hs.sv
// tb_sel_n_1_hs: directed vector table plus hand-written round-robin, reset and invalid-select sequences.
module tb_sel_n_1_hs;
    logic clk = 1'b0;
    logic rst;
    int   applied = 0;
    int   miss = 0;
    always #5 clk = ~clk;
    sel_n_1_hs_if #(.WIDTH(8), .CH(4), .SEL_W(2)) bus ();
    sel_n_1_hs_if #(.WIDTH(8), .CH(3), .SEL_W(2)) bus3 ();
    sel_n_1_hs #(.WIDTH(8), .CH(4), .SEL_W(2), .MAX_BURST(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    sel_n_1_hs #(.WIDTH(8), .CH(3), .SEL_W(2), .MAX_BURST(4)) dut3 (.clk(clk), .rst(rst), .bus(bus3));
    typedef struct {
        logic       mode;
        logic [1:0] sel;
        logic [3:0] iv;
        logic       ordy;
        logic [3:0] ir;
        logic [7:0] out;
        logic       ov;
        logic [1:0] och;
    } vec_t;
    vec_t tbl[11];
    logic [7:0] chdata[4] = '{8'h11, 8'h22, 8'hA5, 8'h44};
    int seq_all[8], seq_13[8], seq_02[9], seq_drop[2];
    logic [3:0] iv_drop[2] = '{4'b0101, 4'b0100};
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask
    task automatic rr_step(input logic [3:0] iv, input int ch);
        logic [3:0] one;
        one = 4'b0001;
        @(negedge clk);
        bus.mode = 1'b1;
        bus.sel = 2'd0;
        bus.out_ready = 1'b1;
        bus.in_valid = iv;
        #1 chk("rr_in_ready", 32'(bus.in_ready), 32'(one << ch));
        @(posedge clk);
        #1;
        chk("rr_out_ch", 32'(bus.out_ch), 32'(ch));
        chk("rr_out", 32'(bus.out), 32'(chdata[ch]));
        chk("rr_out_valid", 32'(bus.out_valid), 32'd1);
    endtask
    initial begin
        tbl[0]  = '{1'b0, 2'd2, 4'hF,    1'b1, 4'b0100, 8'hA5, 1'b1, 2'd2};
        tbl[1]  = '{1'b0, 2'd2, 4'hF,    1'b1, 4'b0100, 8'hA5, 1'b1, 2'd2};
        tbl[2]  = '{1'b0, 2'd1, 4'hF,    1'b0, 4'b0000, 8'hA5, 1'b1, 2'd2};
        tbl[3]  = '{1'b0, 2'd1, 4'hF,    1'b0, 4'b0000, 8'hA5, 1'b1, 2'd2};
        tbl[4]  = '{1'b0, 2'd1, 4'hF,    1'b0, 4'b0000, 8'hA5, 1'b1, 2'd2};
        tbl[5]  = '{1'b0, 2'd1, 4'hF,    1'b1, 4'b0010, 8'h22, 1'b1, 2'd1};
        tbl[6]  = '{1'b0, 2'd2, 4'b1011, 1'b1, 4'b0100, 8'h22, 1'b0, 2'd1};
        tbl[7]  = '{1'b0, 2'd0, 4'b0001, 1'b0, 4'b0001, 8'h11, 1'b1, 2'd0};
        tbl[8]  = '{1'b0, 2'd0, 4'b0001, 1'b0, 4'b0000, 8'h11, 1'b1, 2'd0};
        tbl[9]  = '{1'b0, 2'd3, 4'hF,    1'b1, 4'b1000, 8'h44, 1'b1, 2'd3};
        tbl[10] = '{1'b0, 2'd3, 4'h0,    1'b1, 4'b1000, 8'h44, 1'b0, 2'd3};
`ifdef SEL_LOCK_EN
        seq_all  = '{0, 0, 0, 0, 1, 1, 1, 1};
        seq_13   = '{3, 3, 3, 3, 1, 1, 1, 1};
        seq_02   = '{0, 0, 0, 0, 2, 2, 2, 2, 0};
        seq_drop = '{0, 2};
`else
        seq_all  = '{0, 1, 2, 3, 0, 1, 2, 3};
        seq_13   = '{1, 3, 1, 3, 1, 3, 1, 3};
        seq_02   = '{0, 2, 0, 2, 0, 2, 0, 2, 0};
        seq_drop = '{2, 2};
`endif
        rst = 1'b1;
        bus.in_data = 32'h44A52211;
        bus.in_valid = 4'hF;
        bus.mode = 1'b0;
        bus.sel = 2'd2;
        bus.out_ready = 1'b1;
        bus3.in_data = 24'h33A522;
        bus3.in_valid = 3'b000;
        bus3.mode = 1'b0;
        bus3.sel = 2'd0;
        bus3.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out", 32'(bus.out), 32'd0);
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_out_ch", 32'(bus.out_ch), 32'd0);
        chk("reset_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        bus.in_valid = 4'h0;
        rst = 1'b0;
        foreach (tbl[i]) begin
            @(negedge clk);
            bus.mode = tbl[i].mode;
            bus.sel = tbl[i].sel;
            bus.in_valid = tbl[i].iv;
            bus.out_ready = tbl[i].ordy;
            #1 chk($sformatf("v%0d_in_ready", i), 32'(bus.in_ready), 32'(tbl[i].ir));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_out", i), 32'(bus.out), 32'(tbl[i].out));
            chk($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'(tbl[i].ov));
            chk($sformatf("v%0d_out_ch", i), 32'(bus.out_ch), 32'(tbl[i].och));
        end
        foreach (seq_all[i]) rr_step(4'hF, seq_all[i]);
        foreach (seq_13[i]) rr_step(4'b1010, seq_13[i]);
        // Reset lands mid-cycle while a word is pending; outputs must clear without a clock edge.
        @(negedge clk);
        bus.in_valid = 4'hF;
        chk("pre_reset_out_valid", 32'(bus.out_valid), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("async_reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("async_reset_out", 32'(bus.out), 32'd0);
        chk("async_reset_out_ch", 32'(bus.out_ch), 32'd0);
        chk("async_reset_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("held_reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("held_reset_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        bus.in_valid = 4'h0;
        rst = 1'b0;
        foreach (seq_02[i]) rr_step(4'b0101, seq_02[i]);
        foreach (seq_drop[i]) rr_step(iv_drop[i], seq_drop[i]);
        @(negedge clk);
        bus3.mode = 1'b0;
        bus3.sel = 2'd1;
        bus3.in_valid = 3'b111;
        bus3.out_ready = 1'b1;
        #1 chk("ch3_in_ready_sel1", 32'(bus3.in_ready), 32'b010);
        @(posedge clk);
        #1;
        chk("ch3_out", 32'(bus3.out), 32'hA5);
        chk("ch3_out_ch", 32'(bus3.out_ch), 32'd1);
        chk("ch3_out_valid", 32'(bus3.out_valid), 32'd1);
        @(negedge clk);
        bus3.sel = 2'd3;
        bus3.out_ready = 1'b0;
        #1 chk("ch3_bad_sel_stall_ready", 32'(bus3.in_ready), 32'd0);
        @(posedge clk);
        #1 chk("ch3_bad_sel_stall_valid", 32'(bus3.out_valid), 32'd1);
        @(negedge clk);
        bus3.out_ready = 1'b1;
        #1 chk("ch3_bad_sel_ready", 32'(bus3.in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("ch3_bad_sel_valid_drop", 32'(bus3.out_valid), 32'd0);
        chk("ch3_bad_sel_out_hold", 32'(bus3.out), 32'hA5);
        chk("ch3_bad_sel_ch_hold", 32'(bus3.out_ch), 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", applied, miss);
        $finish;
    end
endmodule
